// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and constants for the N-lane MIPS execute stage
//
// Holds the ALU and MDU opcode enums, the MDU state enum and the exception
// codes used by exec_stage_nway and mdu_iter.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_ADDU  = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_SUBU  = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_XOR   = 4'd6,
        ALU_NOR   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_SLL   = 4'd10,
        ALU_SRL   = 4'd11,
        ALU_SRA   = 4'd12,
        ALU_LUI   = 4'd13,
        ALU_PASSA = 4'd14,
        ALU_PASSB = 4'd15
    } alu_op_e;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // Operations that occupy the MDU for multiple cycles.
    function automatic logic is_mdu_iter_op(mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - shared multi-cycle multiply/divide unit owning HI/LO
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, a, b     launch a MULT/MULTU/DIV/DIVU with operands a, b
//   wr_hi, wr_lo        MTHI/MTLO write strobes, data on wr_data
//   busy                high for every RUN cycle
//   hi, lo              architectural HI/LO registers
//
// Macro EXEC_MDU_EARLY_OUT_EN: divides by zero or with |a| < |b| finish
// after a single busy cycle; otherwise every divide runs DIV_CYCLES.
module mdu_iter
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  mdu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    mdu_op_e           op_q, op_nxt;
    logic [DATA_W-1:0] a_q, a_nxt, b_q, b_nxt;
    logic [DATA_W-1:0] hi_nxt, lo_nxt;

    logic             is_div_in;
    logic             early;
    logic [CNT_W-1:0] cnt_load;

    assign is_div_in = (op == MDU_DIV) || (op == MDU_DIVU);

`ifdef EXEC_MDU_EARLY_OUT_EN
    logic              sgn_in;
    logic [DATA_W-1:0] a_mag_in, b_mag_in;
    assign sgn_in   = (op == MDU_DIV);
    assign a_mag_in = (sgn_in && a[DATA_W-1]) ? -a : a;
    assign b_mag_in = (sgn_in && b[DATA_W-1]) ? -b : b;
    // Quotient is trivially 0 (or all-ones for /0); the normal result path
    // already produces the right HI/LO, only the latency shrinks.
    assign early    = is_div_in && ((b == '0) || (a_mag_in < b_mag_in));
`else
    assign early    = 1'b0;
`endif

    assign cnt_load = early     ? CNT_W'(1) :
                      is_div_in ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

    // Result datapath, evaluated from the latched operands.
    logic                q_div, q_signed, neg_a, neg_b;
    logic [DATA_W-1:0]   a_mag, b_mag, b_div, quo, rem, div_hi, div_lo;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod;

    assign q_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    assign q_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
    assign neg_a    = q_signed && a_q[DATA_W-1];
    assign neg_b    = q_signed && b_q[DATA_W-1];
    assign a_mag    = neg_a ? -a_q : a_q;
    assign b_mag    = neg_b ? -b_q : b_q;
    // Keep the divider defined for a zero divisor; that case is overridden.
    assign b_div    = (b_mag == '0) ? DATA_W'(1) : b_mag;
    assign quo      = a_mag / b_div;
    assign rem      = a_mag % b_div;
    // INT_MIN / -1 falls out naturally: |INT_MIN| wraps to INT_MIN, q = INT_MIN.
    assign div_lo   = (b_q == '0) ? '1  : ((neg_a ^ neg_b) ? -quo : quo);
    assign div_hi   = (b_q == '0) ? a_q : (neg_a ? -rem : rem);

    assign a_ext    = {{DATA_W{neg_a}}, a_q};
    assign b_ext    = {{DATA_W{neg_b}}, b_q};
    assign prod     = a_ext * b_ext;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        hi_nxt    = hi;
        lo_nxt    = lo;
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    state_nxt = MDU_RUN;
                    cnt_nxt   = cnt_load;
                    op_nxt    = op;
                    a_nxt     = a;
                    b_nxt     = b;
                end
                if (wr_hi) hi_nxt = wr_data;
                if (wr_lo) lo_nxt = wr_data;
            end
            MDU_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = MDU_IDLE;
                    cnt_nxt   = '0;
                    if (q_div) begin
                        hi_nxt = div_hi;
                        lo_nxt = div_lo;
                    end else begin
                        hi_nxt = prod[2*DATA_W-1:DATA_W];
                        lo_nxt = prod[DATA_W-1:0];
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MDU_IDLE;
            cnt   <= '0;
            op_q  <= MDU_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

    assign busy = (state == MDU_RUN);

endmodule

// File: rtl/exec_stage_nway.sv
// rtl/exec_stage_nway.sv - N-lane MIPS execute stage with shared MDU arbitration
//
// Ports (per-lane vectors indexed by lane):
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid, in_alu_op, in_mdu_op, in_op_a, in_op_b, in_rd, in_exc
//                                 ID/EX slot contents, operands already forwarded
//   stall, flush                  per-lane hold / kill of the EX/MEM slot
//   out_valid, out_result, out_rd, out_exc
//                                 EX/MEM slot registers
//   mdu_busy                      shared MDU iterating
//   mdu_hazard                    lane must be stalled this cycle
//
// Macro EXEC_MDU_EARLY_OUT_EN: enables divide early-out inside mdu_iter.
module exec_stage_nway
    import exec_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES-1:0]              in_valid,
    input  logic [LANES-1:0][3:0]         in_alu_op,
    input  logic [LANES-1:0][3:0]         in_mdu_op,
    input  logic [LANES-1:0][DATA_W-1:0]  in_op_a,
    input  logic [LANES-1:0][DATA_W-1:0]  in_op_b,
    input  logic [LANES-1:0][4:0]         in_rd,
    input  logic [LANES-1:0][4:0]         in_exc,
    input  logic [LANES-1:0]              stall,
    input  logic [LANES-1:0]              flush,
    output logic [LANES-1:0]              out_valid,
    output logic [LANES-1:0][DATA_W-1:0]  out_result,
    output logic [LANES-1:0][4:0]         out_rd,
    output logic [LANES-1:0][4:0]         out_exc,
    output logic                          mdu_busy,
    output logic [LANES-1:0]              mdu_hazard
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] hi, lo;

    logic [LANES-1:0][DATA_W-1:0] res_nxt;
    logic [LANES-1:0][4:0]        exc_nxt;
    logic [LANES-1:0]             mdu_req;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] a, b, sum, diff, alu_res;
        logic              alu_ov;
        mdu_op_e           mop;

        assign a    = in_op_a[i];
        assign b    = in_op_b[i];
        assign sum  = a + b;
        assign diff = a - b;
        assign mop  = mdu_op_e'(in_mdu_op[i]);

        always_comb begin
            alu_res = '0;
            alu_ov  = 1'b0;
            case (alu_op_e'(in_alu_op[i]))
                ALU_ADD: begin
                    alu_res = sum;
                    alu_ov  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
                end
                ALU_ADDU: alu_res = sum;
                ALU_SUB: begin
                    alu_res = diff;
                    alu_ov  = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
                end
                ALU_SUBU:  alu_res = diff;
                ALU_AND:   alu_res = a & b;
                ALU_OR:    alu_res = a | b;
                ALU_XOR:   alu_res = a ^ b;
                ALU_NOR:   alu_res = ~(a | b);
                ALU_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
                ALU_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (a < b)};
                // Shifts follow the variable-shift form: op_b shifted by op_a.
                ALU_SLL:   alu_res = b << a[SH_W-1:0];
                ALU_SRL:   alu_res = b >> a[SH_W-1:0];
                ALU_SRA:   alu_res = $unsigned($signed(b) >>> a[SH_W-1:0]);
                ALU_LUI:   alu_res = b << (DATA_W / 2);
                ALU_PASSA: alu_res = a;
                ALU_PASSB: alu_res = b;
                default:   alu_res = '0;
            endcase
        end

        assign mdu_req[i] = in_valid[i] && (mop != MDU_NONE) && !flush[i];

        always_comb begin
            case (mop)
                MDU_NONE: res_nxt[i] = alu_res;
                MDU_MFHI: res_nxt[i] = hi;
                MDU_MFLO: res_nxt[i] = lo;
                default:  res_nxt[i] = '0;
            endcase
        end

        // Upstream exception always wins over a locally detected overflow.
        assign exc_nxt[i] = (in_exc[i] != EXC_NONE) ? in_exc[i] :
                            (in_valid[i] && (mop == MDU_NONE) && alu_ov) ? EXC_OV : EXC_NONE;
    end

    // Fixed priority: lowest-index requester owns the MDU this cycle.
    logic [LANES-1:0]  gnt;
    logic              found;
    mdu_op_e           g_op;
    logic [DATA_W-1:0] g_a, g_b;
    logic              g_stall;
    logic [4:0]        g_exc;

    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        g_op    = MDU_NONE;
        g_a     = '0;
        g_b     = '0;
        g_stall = 1'b0;
        g_exc   = EXC_NONE;
        for (int i = 0; i < LANES; i++) begin
            if (mdu_req[i] && !found) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                g_op    = mdu_op_e'(in_mdu_op[i]);
                g_a     = in_op_a[i];
                g_b     = in_op_b[i];
                g_stall = stall[i];
                g_exc   = in_exc[i];
            end
        end
    end

    // Busy is the registered state, so an op arriving on the last busy cycle
    // is still held off even though the result lands at that edge.
    assign mdu_hazard = mdu_req & (~gnt | {LANES{mdu_busy}});

    logic g_accept, mdu_start, wr_hi, wr_lo;
    assign g_accept  = found && !mdu_busy && !g_stall && (g_exc == EXC_NONE);
    assign mdu_start = g_accept && is_mdu_iter_op(g_op);
    assign wr_hi     = g_accept && (g_op == MDU_MTHI);
    assign wr_lo     = g_accept && (g_op == MDU_MTLO);

    mdu_iter #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mdu_start),
        .op      (g_op),
        .a       (g_a),
        .b       (g_b),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (g_a),
        .busy    (mdu_busy),
        .hi      (hi),
        .lo      (lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= '0;
            out_result <= '0;
            out_rd     <= '0;
            out_exc    <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (!stall[i]) begin
                    if (flush[i]) begin
                        out_valid[i]  <= 1'b0;
                        out_result[i] <= '0;
                        out_rd[i]     <= '0;
                        out_exc[i]    <= '0;
                    end else begin
                        out_valid[i]  <= in_valid[i];
                        out_result[i] <= res_nxt[i];
                        out_rd[i]     <= in_rd[i];
                        out_exc[i]    <= exc_nxt[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_nway.sv
// tb/tb_exec_stage_nway.sv - scoreboard testbench for exec_stage_nway
module tb_exec_stage_nway;
    import exec_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       in_valid;
    logic [1:0][3:0]  in_alu_op, in_mdu_op;
    logic [1:0][31:0] in_op_a, in_op_b;
    logic [1:0][4:0]  in_rd, in_exc;
    logic [1:0]       stall_req, flush, stall;
    logic [1:0]       out_valid;
    logic [1:0][31:0] out_result;
    logic [1:0][4:0]  out_rd, out_exc;
    logic             mdu_busy;
    logic [1:0]       mdu_hazard;

    // Acts as the hazard unit: a hazarded lane is held in place.
    assign stall = stall_req | mdu_hazard;

    exec_stage_nway #(.LANES(2), .DATA_W(32), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_op(in_alu_op),
        .in_mdu_op(in_mdu_op), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_rd(in_rd),
        .in_exc(in_exc), .stall(stall), .flush(flush), .out_valid(out_valid),
        .out_result(out_result), .out_rd(out_rd), .out_exc(out_exc),
        .mdu_busy(mdu_busy), .mdu_hazard(mdu_hazard)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [4:0]  exc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [1:0] loaded;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a slot freshly loaded with a valid instruction is popped and compared.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) loaded <= 2'b00;
        else        loaded <= ~stall & ~flush;
    end

    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (loaded[i] && out_valid[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL lane%0d_unexpected: got valid rd=%0d expected no output", i, out_rd[i]);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check($sformatf("lane%0d_result_rd%0d", i, e.rd), out_result[i], e.res);
                        check($sformatf("lane%0d_rd", i), {27'd0, out_rd[i]}, {27'd0, e.rd});
                        check($sformatf("lane%0d_exc_rd%0d", i, e.rd), {27'd0, out_exc[i]}, {27'd0, e.exc});
                    end
                end
            end
        end
    end

    task automatic bubble();
        in_valid = '0; in_alu_op = '0; in_mdu_op = '0; in_op_a = '0;
        in_op_b = '0; in_rd = '0; in_exc = '0; flush = '0; stall_req = '0;
    endtask

    task automatic clr(input int l);
        in_valid[l] = 1'b0; in_mdu_op[l] = 4'd0; in_alu_op[l] = 4'd0;
    endtask

    task automatic put(input int l, input logic [3:0] alu, input logic [3:0] mdu,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [4:0] exc);
        in_valid[l] = 1'b1; in_alu_op[l] = alu; in_mdu_op[l] = mdu;
        in_op_a[l] = a; in_op_b[l] = b; in_rd[l] = rd; in_exc[l] = exc;
    endtask

    task automatic expect_out(input int l, input logic [31:0] r, input logic [4:0] rd, input logic [4:0] exc);
        exp_t x;
        x.res = r; x.rd = rd; x.exc = exc;
        if (l == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!mdu_busy) return;
            n++;
        end
    endtask

    int n;
    int div0_cycles;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef EXEC_MDU_EARLY_OUT_EN
        div0_cycles = 1;
`else
        div0_cycles = 32;
`endif
        bubble();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {30'd0, out_valid}, 32'd0);
        check("rst_result0", out_result[0], 32'd0);
        check("rst_result1", out_result[1], 32'd0);
        check("rst_busy", {31'd0, mdu_busy}, 32'd0);
        check("rst_hazard", {30'd0, mdu_hazard}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU patterns: overflow, upstream exception precedence, compares, shifts.
        put(0, ALU_ADD,  MDU_NONE, 32'h7FFFFFFF, 32'h1, 5'd3, 5'd0);
        put(1, ALU_ADDU, MDU_NONE, 32'h7FFFFFFF, 32'h1, 5'd4, 5'd0);
        expect_out(0, 32'h80000000, 5'd3, EXC_OV);
        expect_out(1, 32'h80000000, 5'd4, 5'd0);
        tick();
        put(0, ALU_SUB, MDU_NONE, 32'h80000000, 32'h1, 5'd5, 5'd0);
        put(1, ALU_ADD, MDU_NONE, 32'h7FFFFFFF, 32'h1, 5'd6, 5'd5);
        expect_out(0, 32'h7FFFFFFF, 5'd5, EXC_OV);
        expect_out(1, 32'h80000000, 5'd6, 5'd5);
        tick();
        put(0, ALU_SLT,  MDU_NONE, 32'hFFFFFFFF, 32'h1, 5'd7, 5'd0);
        put(1, ALU_SLTU, MDU_NONE, 32'hFFFFFFFF, 32'h1, 5'd8, 5'd0);
        expect_out(0, 32'h1, 5'd7, 5'd0);
        expect_out(1, 32'h0, 5'd8, 5'd0);
        tick();
        put(0, ALU_SRA, MDU_NONE, 32'h4, 32'h80000000, 5'd9, 5'd0);
        put(1, ALU_NOR, MDU_NONE, 32'h0F0F0F0F, 32'h00FF00FF, 5'd10, 5'd0);
        expect_out(0, 32'hF8000000, 5'd9, 5'd0);
        expect_out(1, 32'hF000F000, 5'd10, 5'd0);
        tick();
        put(0, ALU_ADD, MDU_NONE, 32'h1, 32'h2, 5'd11, 5'd0);
        put(1, ALU_ADD, MDU_NONE, 32'h1, 32'h2, 5'd12, 5'd0);
        flush[0] = 1'b1;
        expect_out(1, 32'h3, 5'd12, 5'd0);
        tick();
        check("flush_valid", {30'd0, out_valid}, 32'h2);
        check("flush_rd0", {27'd0, out_rd[0]}, 32'd0);
        bubble();

        // MULT -1 * 2, busy length, hazard while busy, back-to-back MFHI/MFLO.
        put(0, ALU_ADD, MDU_MULT, 32'hFFFFFFFF, 32'h2, 5'd0, 5'd0);
        expect_out(0, 32'h0, 5'd0, 5'd0);
        tick();
        bubble();
        check("mul_busy_started", {31'd0, mdu_busy}, 32'd1);
        put(0, ALU_ADD, MDU_MFHI, 32'h0, 32'h0, 5'd1, 5'd0);
        #1;
        check("busy_hazard", {30'd0, mdu_hazard}, 32'h1);
        bubble();
        count_busy(n);
        check("mul_busy_cycles", n, 32'd4);
        #1;
        put(0, ALU_ADD, MDU_MFHI, 32'h0, 32'h0, 5'd13, 5'd0);
        expect_out(0, 32'hFFFFFFFF, 5'd13, 5'd0);
        tick();
        put(0, ALU_ADD, MDU_MFLO, 32'h0, 32'h0, 5'd14, 5'd0);
        expect_out(0, 32'hFFFFFFFE, 5'd14, 5'd0);
        tick();

        // Both lanes MFLO: lane0 first, lane1 held one cycle.
        put(0, ALU_ADD, MDU_MFLO, 32'h0, 32'h0, 5'd15, 5'd0);
        put(1, ALU_ADD, MDU_MFLO, 32'h0, 32'h0, 5'd16, 5'd0);
        #1;
        check("dual_mflo_hazard", {30'd0, mdu_hazard}, 32'h2);
        expect_out(0, 32'hFFFFFFFE, 5'd15, 5'd0);
        tick();
        clr(0);
        #1;
        check("dual_mflo_hazard_clear", {30'd0, mdu_hazard}, 32'h0);
        expect_out(1, 32'hFFFFFFFE, 5'd16, 5'd0);
        tick();
        bubble();

        // DIV 7 / 0.
        put(0, ALU_ADD, MDU_DIV, 32'h7, 32'h0, 5'd0, 5'd0);
        expect_out(0, 32'h0, 5'd0, 5'd0);
        tick();
        bubble();
        count_busy(n);
        check("div0_busy_cycles", n, div0_cycles);
        #1;
        put(0, ALU_ADD, MDU_MFLO, 32'h0, 32'h0, 5'd17, 5'd0);
        expect_out(0, 32'hFFFFFFFF, 5'd17, 5'd0);
        tick();
        put(0, ALU_ADD, MDU_MFHI, 32'h0, 32'h0, 5'd18, 5'd0);
        expect_out(0, 32'h7, 5'd18, 5'd0);
        tick();
        bubble();

        // INT_MIN / -1 on lane1, lane1 flushed two cycles after start.
        put(0, ALU_ADDU, MDU_NONE, 32'h5, 32'h6, 5'd19, 5'd0);
        put(1, ALU_ADD, MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 5'd0);
        expect_out(0, 32'hB, 5'd19, 5'd0);
        expect_out(1, 32'h0, 5'd0, 5'd0);
        tick();
        bubble();
        tick();
        put(1, ALU_ADD, MDU_NONE, 32'h1, 32'h1, 5'd20, 5'd0);
        flush[1] = 1'b1;
        tick();
        check("flush_issuer_valid", {31'd0, out_valid[1]}, 32'd0);
        bubble();
        count_busy(n);
        check("intmin_busy_rest", n, 32'd30);
        #1;
        put(0, ALU_ADD, MDU_MFLO, 32'h0, 32'h0, 5'd21, 5'd0);
        expect_out(0, 32'h80000000, 5'd21, 5'd0);
        tick();
        put(0, ALU_ADD, MDU_MFHI, 32'h0, 32'h0, 5'd22, 5'd0);
        expect_out(0, 32'h0, 5'd22, 5'd0);
        tick();
        bubble();

        // Signed divide -7 / 2: quotient -3, remainder -1.
        put(0, ALU_ADD, MDU_DIV, 32'hFFFFFFF9, 32'h2, 5'd0, 5'd0);
        expect_out(0, 32'h0, 5'd0, 5'd0);
        tick();
        bubble();
        count_busy(n);
        check("sdiv_busy_cycles", n, 32'd32);
        #1;
        put(0, ALU_ADD, MDU_MFLO, 32'h0, 32'h0, 5'd1, 5'd0);
        expect_out(0, 32'hFFFFFFFD, 5'd1, 5'd0);
        tick();
        put(0, ALU_ADD, MDU_MFHI, 32'h0, 32'h0, 5'd2, 5'd0);
        expect_out(0, 32'hFFFFFFFF, 5'd2, 5'd0);
        tick();

        // MTHI writes; MTLO carrying an exception must not.
        put(0, ALU_ADD, MDU_MTHI, 32'h12345678, 32'h0, 5'd0, 5'd0);
        expect_out(0, 32'h0, 5'd0, 5'd0);
        tick();
        put(0, ALU_ADD, MDU_MFHI, 32'h0, 32'h0, 5'd23, 5'd0);
        expect_out(0, 32'h12345678, 5'd23, 5'd0);
        tick();
        put(0, ALU_ADD, MDU_MTLO, 32'hDEADBEEF, 32'h0, 5'd24, 5'd5);
        expect_out(0, 32'h0, 5'd24, 5'd5);
        tick();
        put(0, ALU_ADD, MDU_MFLO, 32'h0, 32'h0, 5'd25, 5'd0);
        expect_out(0, 32'hFFFFFFFD, 5'd25, 5'd0);
        tick();
        bubble();

        // Reset while the MDU is running.
        put(0, ALU_ADD, MDU_MULT, 32'h3, 32'h5, 5'd0, 5'd0);
        expect_out(0, 32'h0, 5'd0, 5'd0);
        tick();
        bubble();
        put(1, ALU_ADD, MDU_NONE, 32'h2, 32'h3, 5'd26, 5'd0);
        expect_out(1, 32'h5, 5'd26, 5'd0);
        tick();
        bubble();
        @(negedge clk);
        check("pre_reset_busy", {31'd0, mdu_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", {31'd0, mdu_busy}, 32'd0);
        check("midrun_rst_valid", {30'd0, out_valid}, 32'd0);
        check("midrun_rst_result1", out_result[1], 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        put(0, ALU_ADD, MDU_MFHI, 32'h0, 32'h0, 5'd27, 5'd0);
        expect_out(0, 32'h0, 5'd27, 5'd0);
        tick();
        put(0, ALU_ADD, MDU_MFLO, 32'h0, 32'h0, 5'd28, 5'd0);
        expect_out(0, 32'h0, 5'd28, 5'd0);
        tick();
        bubble();
        repeat (3) tick();
        check("post_reset_busy", {31'd0, mdu_busy}, 32'd0);

        check("lane0_drain", q0.size(), 32'd0);
        check("lane1_drain", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
